// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module : counter_pkg
// Brief  : Opcode and FSM state encodings shared by the up/down counter unit.
// Rev    : 1.0
// ============================================================================
package counter_pkg;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_CLR       = 3'd1;
    localparam logic [2:0] OP_INC       = 3'd2;
    localparam logic [2:0] OP_DEC       = 3'd3;
    localparam logic [2:0] OP_LOAD      = 3'd4;
    localparam logic [2:0] OP_RUN_UP    = 3'd5;
    localparam logic [2:0] OP_RUN_DN    = 3'd6;
    localparam logic [2:0] OP_CLR_FLAGS = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/counter_step.sv
`default_nettype none
// ============================================================================
// Module : counter_step
// Brief  : One increment/decrement step with limit detection (saturate/wrap).
// Rev    : 1.0
// ============================================================================
module counter_step #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b1
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_next,
    output logic             o_limit_hit
);

    localparam logic [WIDTH:0] c_max_ext = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] c_one     = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // One spare bit so MAX_VAL = 2**WIDTH-1 overflows detectably instead of aliasing to 0
    assign w_sum  = {1'b0, i_value} + c_one;
    assign w_diff = {1'b0, i_value} - c_one;

    always_comb begin
        o_next      = i_value;
        o_limit_hit = 1'b0;
        if (i_dir) begin
            if (w_sum > c_max_ext) begin
                o_limit_hit = 1'b1;
                o_next      = SATURATE ? i_value : {WIDTH{1'b0}};
            end else begin
                o_next = w_sum[WIDTH-1:0];
            end
        end else begin
            if (w_diff[WIDTH]) begin
                o_limit_hit = 1'b1;
                o_next      = SATURATE ? i_value : MAX_VAL;
            end else begin
                o_next = w_diff[WIDTH-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/updown_counter_unit.sv
`default_nettype none
// ============================================================================
// Module : updown_counter_unit
// Brief  : Command-driven up/down counter with limit, run/abort and sticky ovf.
// Rev    : 1.0
// ============================================================================
module updown_counter_unit
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic [WIDTH-1:0] c_out,
    output logic             z,
    output logic             m,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_remaining;
    logic             r_dir;
    logic             r_ovf;
    logic             r_done;

    logic             w_accept;
    logic             w_is_run_op;
    logic             w_run_start;
    logic             w_last_step;
    logic             w_step_dir;
    logic [WIDTH-1:0] w_step_next;
    logic             w_step_hit;
    logic [WIDTH-1:0] w_load_val;

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_is_run_op = (cmd_op == OP_RUN_UP) || (cmd_op == OP_RUN_DN);
    assign w_run_start = w_accept && w_is_run_op && (cmd_arg != {WIDTH{1'b0}});
    assign w_last_step = (r_remaining == {{(WIDTH-1){1'b0}}, 1'b1});
    assign w_load_val  = (cmd_arg > MAX_VAL) ? MAX_VAL : cmd_arg;

    // The single stepper serves INC/DEC in IDLE and the latched direction in RUN
    assign w_step_dir = (r_state == ST_RUN) ? r_dir : (cmd_op == OP_INC);

    counter_step #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_step (
        .i_value     (r_count),
        .i_dir       (w_step_dir),
        .o_next      (w_step_next),
        .o_limit_hit (w_step_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_run_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (abort || w_last_step) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == ST_IDLE);
        busy      = (r_state == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= {WIDTH{1'b0}};
            r_remaining <= {WIDTH{1'b0}};
            r_dir       <= 1'b0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_RUN) begin
                if (abort) begin
                    r_done <= 1'b1;
                end else begin
                    r_count     <= w_step_next;
                    r_remaining <= r_remaining - {{(WIDTH-1){1'b0}}, 1'b1};
                    if (w_step_hit) r_ovf <= 1'b1;
                    if (w_last_step) r_done <= 1'b1;
                end
            end else if (w_accept) begin
                // A non-zero run reports completion later; everything else finishes now
                r_done <= !w_run_start;
                case (cmd_op)
                    OP_CLR:  r_count <= {WIDTH{1'b0}};
                    OP_INC, OP_DEC: begin
                        r_count <= w_step_next;
                        if (w_step_hit) r_ovf <= 1'b1;
                    end
                    OP_LOAD: r_count <= w_load_val;
                    OP_RUN_UP, OP_RUN_DN: begin
                        r_remaining <= cmd_arg;
                        r_dir       <= (cmd_op == OP_RUN_UP);
                    end
                    OP_CLR_FLAGS: r_ovf <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign c_out = r_count;
    assign ovf   = r_ovf;
    assign done  = r_done;
    assign z     = (r_count == {WIDTH{1'b0}});
    assign m     = (r_count == MAX_VAL);

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_updown_counter_unit
// Brief  : Two DUTs (16-bit saturating, MAX_VAL=9 wrapping) on shared stimulus.
// Rev    : 1.0
// ============================================================================
module tb_updown_counter_unit;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic             abort;

    logic [WIDTH-1:0] c_out_s, c_out_w;
    logic rdy_s, z_s, m_s, ovf_s, busy_s, done_s;
    logic rdy_w, z_w, m_w, ovf_w, busy_w, done_w;

    always #5 clk = ~clk;

    updown_counter_unit #(.WIDTH(WIDTH), .MAX_VAL(16'hFFFF), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy_s), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .abort(abort), .c_out(c_out_s), .z(z_s), .m(m_s), .ovf(ovf_s),
        .busy(busy_s), .done(done_s));

    updown_counter_unit #(.WIDTH(WIDTH), .MAX_VAL(16'd9), .SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy_w), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .abort(abort), .c_out(c_out_w), .z(z_w), .m(m_w), .ovf(ovf_w),
        .busy(busy_w), .done(done_w));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: index 0 = saturating DUT, index 1 = wrapping DUT
    longint m_val [2];
    bit     m_ovf [2];
    longint m_max [2];
    bit     m_sat [2];
    bit     m_busy, m_done, m_dir;
    longint m_rem;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0;
            m_ovf[k] = 0;
        end
        m_busy = 0; m_done = 0; m_dir = 0; m_rem = 0;
    endtask

    task automatic model_step(int k, bit up);
        if (up) begin
            if (m_val[k] == m_max[k]) begin
                m_ovf[k] = 1;
                if (!m_sat[k]) m_val[k] = 0;
            end else m_val[k] = m_val[k] + 1;
        end else begin
            if (m_val[k] == 0) begin
                m_ovf[k] = 1;
                if (!m_sat[k]) m_val[k] = m_max[k];
            end else m_val[k] = m_val[k] - 1;
        end
    endtask

    task automatic model_edge();
        bit nd = 0;
        if (m_busy) begin
            if (abort) begin
                m_busy = 0; nd = 1;
            end else begin
                for (int k = 0; k < 2; k++) model_step(k, m_dir);
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_busy = 0; nd = 1; end
            end
        end else if (cmd_valid) begin
            nd = 1;
            for (int k = 0; k < 2; k++) begin
                case (cmd_op)
                    3'd1: m_val[k] = 0;
                    3'd2: model_step(k, 1'b1);
                    3'd3: model_step(k, 1'b0);
                    3'd4: m_val[k] = (longint'(cmd_arg) > m_max[k]) ? m_max[k] : longint'(cmd_arg);
                    3'd7: m_ovf[k] = 0;
                    default: ;
                endcase
            end
            if ((cmd_op == 3'd5 || cmd_op == 3'd6) && cmd_arg != 0) begin
                m_busy = 1; m_rem = longint'(cmd_arg); m_dir = (cmd_op == 3'd5); nd = 0;
            end
        end
        m_done = nd;
    endtask

    function automatic logic [21:0] obs(int k);
        if (k == 0) return {c_out_s, z_s, m_s, ovf_s, busy_s, done_s, rdy_s};
        return {c_out_w, z_w, m_w, ovf_w, busy_w, done_w, rdy_w};
    endfunction

    function automatic logic [21:0] expd(int k);
        return {WIDTH'(m_val[k]), m_val[k] == 0, m_val[k] == m_max[k], m_ovf[k],
                m_busy, m_done, !m_busy};
    endfunction

    task automatic compare_all();
        check("model_sat",  {42'd0, obs(0)}, {42'd0, expd(0)});
        check("model_wrap", {42'd0, obs(1)}, {42'd0, expd(1)});
    endtask

    task automatic drive(bit v, logic [2:0] op, logic [WIDTH-1:0] arg, bit ab);
        cmd_valid = v; cmd_op = op; cmd_arg = arg; abort = ab;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] arg;
        longint      c_s;
        bit          o_s;
        longint      c_w;
        bit          o_w;
    } vec_t;

    vec_t tbl [11];
    int   cnt_busy, cnt_nrdy, cnt_done;
    longint exp_seq [4];

    initial begin
        m_max[0] = 65535; m_sat[0] = 1;
        m_max[1] = 9;     m_sat[1] = 0;

        tbl[0]  = '{3'd1, 16'd0,     0,     0, 0, 0};
        tbl[1]  = '{3'd2, 16'd0,     1,     0, 1, 0};
        tbl[2]  = '{3'd2, 16'd0,     2,     0, 2, 0};
        tbl[3]  = '{3'd2, 16'd0,     3,     0, 3, 0};
        tbl[4]  = '{3'd3, 16'd0,     2,     0, 2, 0};
        tbl[5]  = '{3'd3, 16'd0,     1,     0, 1, 0};
        tbl[6]  = '{3'd4, 16'd65534, 65534, 0, 9, 0};
        tbl[7]  = '{3'd2, 16'd0,     65535, 0, 0, 1};
        tbl[8]  = '{3'd2, 16'd0,     65535, 1, 1, 1};
        tbl[9]  = '{3'd7, 16'd0,     65535, 0, 1, 0};
        tbl[10] = '{3'd4, 16'd8,     8,     0, 8, 0};

        reset = 1'b1;
        drive(0, 3'd0, '0, 0);
        #1 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(1, tbl[i].op, tbl[i].arg, 0);
            tick();
            check($sformatf("tbl%0d", i),
                  {24'd0, c_out_s, ovf_s, m_s, done_s, c_out_w, ovf_w, done_w},
                  {24'd0, WIDTH'(tbl[i].c_s), tbl[i].o_s, tbl[i].c_s == 65535, 1'b1,
                   WIDTH'(tbl[i].c_w), tbl[i].o_w, 1'b1});
        end

        // Wrapping run: 8 -> 9,0,1,2
        exp_seq[0] = 9; exp_seq[1] = 0; exp_seq[2] = 1; exp_seq[3] = 2;
        drive(1, 3'd5, 16'd4, 0);
        tick();
        drive(0, 3'd0, '0, 0);
        cnt_busy = int'(busy_w); cnt_nrdy = int'(!rdy_w); cnt_done = int'(done_w);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 4) check($sformatf("run_up_c%0d", i), {48'd0, c_out_w}, {48'd0, WIDTH'(exp_seq[i])});
            cnt_busy += int'(busy_w); cnt_nrdy += int'(!rdy_w); cnt_done += int'(done_w);
        end
        check("run_up_busy_cycles", 64'(cnt_busy), 64'd4);
        check("run_up_nrdy_cycles", 64'(cnt_nrdy), 64'd4);
        check("run_up_done_pulses", 64'(cnt_done), 64'd1);
        check("run_up_ovf", {63'd0, ovf_w}, 64'd1);

        // RUN_DN 10 from 5, abort sampled on the third run edge
        drive(1, 3'd4, 16'd5, 0);
        tick();
        drive(1, 3'd6, 16'd10, 0);
        tick();
        drive(0, 3'd0, '0, 0);
        cnt_done = int'(done_w);
        tick();
        tick();
        cnt_done += int'(done_w);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cnt_done += int'(done_w);
        check("abort_state", {40'd0, c_out_s, c_out_w, busy_s, rdy_s, done_s, busy_w, rdy_w, done_w},
              {40'd0, 16'd3, 16'd3, 6'b011_011});
        tick();
        cnt_done += int'(done_w);
        check("abort_done_pulses", 64'(cnt_done), 64'd1);

        // RUN_UP 5 with cmd_valid held, INC queued behind it
        drive(1, 3'd1, '0, 0);
        tick();
        drive(1, 3'd5, 16'd5, 0);
        tick();
        drive(1, 3'd2, '0, 0);
        cnt_done = int'(done_s);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) check("held_inc_not_early", {46'd0, c_out_s, rdy_s, done_s}, {46'd0, 16'd5, 2'b11});
            if (i == 6) drive(0, 3'd0, '0, 0);
            cnt_done += int'(done_s);
        end
        tick();
        cnt_done += int'(done_s);
        check("held_inc_final", {32'd0, c_out_s, c_out_w}, {32'd0, 16'd6, 16'd6});
        check("held_inc_done_pulses", 64'(cnt_done), 64'd2);

        // Asynchronous reset in the middle of a run
        drive(1, 3'd5, 16'd7, 0);
        tick();
        drive(0, 3'd0, '0, 0);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        check("async_reset", {28'd0, c_out_s, c_out_w, busy_s, done_s, busy_w, done_w},
              {28'd0, 16'd0, 16'd0, 4'b0000});
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
        drive(1, 3'd4, 16'd4, 0);
        tick();
        drive(1, 3'd5, 16'd0, 0);
        tick();
        check("run_zero", {28'd0, c_out_s, c_out_w, busy_s, done_s, rdy_s, done_w},
              {28'd0, 16'd4, 16'd4, 4'b0111});
        drive(0, 3'd0, '0, 0);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12)),
                  $urandom_range(0, 15) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updown_counter_unit.md
Name: updown_counter_unit

Overview:
- Parametrised successor of the 16-bit inc/dec counter datapath.
- Adds generic width, programmable upper limit, and a selectable saturate or wrap policy.
- Adds a command handshake with single-step, load and multi-step run operations, abort, and a sticky overflow flag.
- Sits between the system controller, which issues commands, and any logic consuming c_out, z and m.

Parameters:
- WIDTH, 16: counter width in bits.
- MAX_VAL, 2**WIDTH-1: upper count limit; m asserts at this value.
- SATURATE, 1: 1 = hold at the limits; 0 = wrap (MAX_VAL+1 -> 0, 0-1 -> MAX_VAL).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  opcode (see Behaviour).
- cmd_arg  in  WIDTH  load value or step count.
- abort  in  1  terminates a RUN in progress.
- c_out  out  WIDTH  counter value.
- z  out  1  c_out == 0.
- m  out  1  c_out == MAX_VAL.
- ovf  out  1  sticky overflow/underflow flag.
- busy  out  1  multi-step run in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (reset=0, asynchronous): c_out=0, ovf=0, busy=0, done=0, FSM=IDLE, cmd_ready=1. z=1 and m=0 follow from decode; m=1 if MAX_VAL==0.
- Reset asserted mid-RUN aborts the run immediately. No done pulse is produced.
- z and m are combinational decodes of the c_out register.
- Accept rule: a command is taken on the edge where cmd_valid=1 and cmd_ready=1. cmd_ready=1 only in IDLE.
- Opcodes:
  - 0 NOP: no change.
  - 1 CLR: c_out=0.
  - 2 INC: c_out+1.
  - 3 DEC: c_out-1.
  - 4 LOAD: c_out=min(cmd_arg, MAX_VAL).
  - 5 RUN_UP: cmd_arg increments.
  - 6 RUN_DN: cmd_arg decrements.
  - 7 CLR_FLAGS: ovf=0.
- Single-cycle ops (0-4, 7):
  - Accepted at edge T; new c_out is visible after edge T.
  - done=1 for the cycle following edge T.
  - FSM stays IDLE.
- RUN_UP/RUN_DN with cmd_arg=0: treated as a single-cycle NOP; done pulses next cycle.
- RUN_UP/RUN_DN with cmd_arg=N>0:
  - Edge T: FSM -> RUN, remaining=N, direction latched, busy=1, cmd_ready=0.
  - One step is applied per edge T+1..T+N; remaining decrements each step.
  - On the edge applying the final step: FSM -> IDLE, busy=0, cmd_ready=1.
  - done pulses in the following cycle, i.e. c_out final after edge T+N, done high during cycle T+N.
- Abort in RUN: sampled on an edge with abort=1, no step is applied, FSM -> IDLE, done pulses next cycle. abort is ignored in IDLE.
- Limit handling for INC or RUN_UP step at MAX_VAL:
  - SATURATE=1: c_out holds, ovf<=1.
  - SATURATE=0: c_out<=0, ovf<=1.
- Limit handling for DEC or RUN_DN step at 0:
  - SATURATE=1: c_out holds, ovf<=1.
  - SATURATE=0: c_out<=MAX_VAL, ovf<=1.
- A saturating run keeps consuming steps at the limit, so its duration stays N cycles.
- ovf is sticky. Only CLR_FLAGS or reset clears it; CLR does not.
- LOAD with cmd_arg>MAX_VAL clamps to MAX_VAL and does not set ovf.
- All arithmetic is done in WIDTH+1 bits before the limit compare, so MAX_VAL=2**WIDTH-1 wraps correctly.

Decomposition:
- Package counter_pkg holds:
  - opcode localparams OP_NOP..OP_CLR_FLAGS (3 bits);
  - FSM state encoding ST_IDLE, ST_RUN.
- One combinational sub-module, counter_step: inputs value, dir, parameters WIDTH/MAX_VAL/SATURATE; outputs next value and a limit-hit bit.
- counter_step is shared by INC/DEC and the RUN path.
- Top level holds the FSM, the remaining-step counter, and the c_out/ovf/done registers.

Test Plan:
- Reset, then CLR, then INC x3 (WIDTH=16) -> c_out=3, z=0, m=0, three done pulses, ovf=0; then DEC x2 -> c_out=1.
- LOAD 65534, INC, INC with SATURATE=1 -> c_out=65535, m=1 after the first INC, held at 65535 after the second, ovf=1; CLR_FLAGS -> ovf=0.
- SATURATE=0, MAX_VAL=9: LOAD 8, RUN_UP 4 -> c_out sequence 9,0,1,2, ovf=1, busy high 4 cycles, cmd_ready low 4 cycles, single done pulse.
- RUN_DN 10 from c_out=5, abort asserted on the 3rd run cycle -> c_out=3, FSM IDLE next cycle, done pulses once, cmd_ready=1.
- cmd_valid held high with RUN_UP 5 followed by INC -> INC is accepted only after the run's final edge; c_out=6 from 0, with exactly 2 done pulses.
- reset driven low mid-RUN_UP, between clock edges -> c_out=0, busy=0, done=0 immediately; RUN_UP 0 after release -> done pulses, c_out unchanged.
